// File: rtl/id_hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// id_hazard_scoreboard_if : ID/WB-side signal bundle for the hazard scoreboard
// Rev 1.0
// ============================================================================
interface id_hazard_scoreboard_if #(
  parameter int NUM_REGS = 16
);
  localparam int IDX_W = $clog2(NUM_REGS);

  logic                id_valid;
  logic                id_wb_en;
  logic [IDX_W-1:0]    id_dest;
  logic [IDX_W-1:0]    id_src1;
  logic [IDX_W-1:0]    id_src2;
  logic                id_has_src1;
  logic                id_two_src;
  logic                freeze;
  logic                flush;
  logic                wb_wb_en;
  logic [IDX_W-1:0]    wb_dest;
  logic                hazard;
  logic [NUM_REGS-1:0] pending_mask;
  logic [3:0]          inflight_cnt;
  logic                underflow_err;

  modport master (
    output id_valid, id_wb_en, id_dest, id_src1, id_src2, id_has_src1,
           id_two_src, freeze, flush, wb_wb_en, wb_dest,
    input  hazard, pending_mask, inflight_cnt, underflow_err
  );

  modport slave (
    input  id_valid, id_wb_en, id_dest, id_src1, id_src2, id_has_src1,
           id_two_src, freeze, flush, wb_wb_en, wb_dest,
    output hazard, pending_mask, inflight_cnt, underflow_err
  );
endinterface
`default_nettype wire

// File: rtl/id_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// id_hazard_scoreboard : per-register pending-write counters driving ID stall
// Rev 1.0
// ============================================================================
module id_hazard_scoreboard #(
  parameter int NUM_REGS     = 16,
  parameter int MAX_INFLIGHT = 3,
  parameter int CNT_W        = 2
) (
  input wire clk,
  input wire rst,
  id_hazard_scoreboard_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [CNT_W-1:0] c_MAX_CNT = CNT_W'(MAX_INFLIGHT);

  logic [CNT_W-1:0]    w_pend [NUM_REGS];
  logic [NUM_REGS-1:0] w_pending;
  logic                w_raw;
  logic                w_ovf;
  logic                w_hazard;
  logic                w_issue;
  logic                w_commit;
  logic                w_same_reg;
  logic                w_underflow;
  logic                w_valid_commit;
  logic [3:0]          r_inflight;
  logic                r_underflow;

  always_comb begin
    w_raw = (bus.id_has_src1 && (w_pend[bus.id_src1] != '0)) ||
            (bus.id_two_src  && (w_pend[bus.id_src2] != '0));
    w_ovf = bus.id_wb_en && (w_pend[bus.id_dest] == c_MAX_CNT);
    // freeze does not mask the stall; it only blocks state updates below
    w_hazard   = bus.id_valid && !bus.flush && (w_raw || w_ovf);
    w_issue    = bus.id_valid && !w_hazard && !bus.freeze && !bus.flush && bus.id_wb_en;
    w_commit   = bus.wb_wb_en && !bus.freeze;
    w_same_reg = w_issue && w_commit && (bus.id_dest == bus.wb_dest);
    w_underflow    = w_commit && (w_pend[bus.wb_dest] == '0) && !w_same_reg;
    w_valid_commit = w_commit && !w_underflow;
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    logic             w_inc;
    logic             w_dec;
    logic [CNT_W-1:0] r_cnt;

    assign w_inc        = w_issue  && (bus.id_dest == IDX_W'(g));
    assign w_dec        = w_commit && (bus.wb_dest == IDX_W'(g));
    assign w_pend[g]    = r_cnt;
    assign w_pending[g] = (r_cnt != '0);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_cnt <= '0;
      end else if (w_inc && !w_dec) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_dec && !w_inc && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Same-cycle issue and valid commit cancel; the total saturates at both ends
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inflight  <= 4'd0;
      r_underflow <= 1'b0;
    end else begin
      if (w_underflow) begin
        r_underflow <= 1'b1;
      end
      if (w_issue && !w_valid_commit && (r_inflight != 4'hF)) begin
        r_inflight <= r_inflight + 4'd1;
      end else if (w_valid_commit && !w_issue && (r_inflight != 4'h0)) begin
        r_inflight <= r_inflight - 4'd1;
      end
    end
  end

  assign bus.hazard        = w_hazard;
  assign bus.pending_mask  = w_pending;
  assign bus.inflight_cnt  = r_inflight;
  assign bus.underflow_err = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_id_hazard_scoreboard.sv
`default_nettype none
// Scoreboard-based bench for id_hazard_scoreboard: post-edge state expectations
// are queued from a bench model when stimulus is applied, hazard is hand-specified.
module tb_id_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  id_hazard_scoreboard_if #(.NUM_REGS(16)) bus ();

  id_hazard_scoreboard #(
    .NUM_REGS(16), .MAX_INFLIGHT(3), .CNT_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic       valid;
    logic       wb_en;
    logic [3:0] dest;
    logic [3:0] src1;
    logic       has1;
    logic [3:0] src2;
    logic       two;
    logic       frz;
    logic       fl;
    logic       wbwb;
    logic [3:0] wbd;
    logic       exp_h;
  } stim_t;

  typedef logic [20:0] exp_t;  // {pending_mask, inflight_cnt, underflow_err}

  int   n_chk  = 0;
  int   n_fail = 0;
  int   m_pend [16];
  int   m_infl;
  bit   m_uf;
  exp_t exp_q [$];

  function automatic stim_t mk(input logic valid, input logic wb_en, input logic [3:0] dest,
                               input logic [3:0] src1, input logic has1, input logic [3:0] src2,
                               input logic two, input logic frz, input logic fl,
                               input logic wbwb, input logic [3:0] wbd, input logic exp_h);
    stim_t s;
    s.valid = valid; s.wb_en = wb_en; s.dest = dest; s.src1 = src1; s.has1 = has1;
    s.src2 = src2; s.two = two; s.frz = frz; s.fl = fl; s.wbwb = wbwb; s.wbd = wbd;
    s.exp_h = exp_h;
    return s;
  endfunction

  function automatic stim_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic bit model_haz(input stim_t s);
    return s.valid && !s.fl && ((s.has1 && m_pend[s.src1] != 0) ||
           (s.two && m_pend[s.src2] != 0) || (s.wb_en && m_pend[s.dest] == 3));
  endfunction

  task automatic model_reset();
    foreach (m_pend[r]) m_pend[r] = 0;
    m_infl = 0;
    m_uf   = 1'b0;
  endtask

  task automatic apply(input stim_t s);
    bus.id_valid    = s.valid;
    bus.id_wb_en    = s.wb_en;
    bus.id_dest     = s.dest;
    bus.id_src1     = s.src1;
    bus.id_has_src1 = s.has1;
    bus.id_src2     = s.src2;
    bus.id_two_src  = s.two;
    bus.freeze      = s.frz;
    bus.flush       = s.fl;
    bus.wb_wb_en    = s.wbwb;
    bus.wb_dest     = s.wbd;
  endtask

  // Advance the model by one edge, queue the expected post-edge state, then clock.
  task automatic tick(input stim_t s);
    bit          h, iss, com, vc;
    logic [15:0] mask;
    h   = model_haz(s);
    iss = s.valid && !h && !s.frz && !s.fl && s.wb_en;
    com = s.wbwb && !s.frz;
    vc  = 1'b0;
    if (iss && com && (s.dest == s.wbd)) begin
      vc = 1'b1;
    end else begin
      if (iss) m_pend[s.dest]++;
      if (com) begin
        if (m_pend[s.wbd] > 0) begin
          m_pend[s.wbd]--;
          vc = 1'b1;
        end else begin
          m_uf = 1'b1;
        end
      end
    end
    if (iss && !vc) m_infl = (m_infl < 15) ? m_infl + 1 : 15;
    else if (vc && !iss) m_infl = (m_infl > 0) ? m_infl - 1 : 0;
    for (int r = 0; r < 16; r++) mask[r] = (m_pend[r] != 0);
    exp_q.push_back({mask, 4'(m_infl), m_uf});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    apply(mk(1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 0));
    #2;
    n_chk++; if (bus.hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard: got %b want 0", bus.hazard); end
    n_chk++; if (bus.pending_mask !== 16'h0) begin n_fail++; $display("FAIL reset_mask: got %h want 0000", bus.pending_mask); end
    n_chk++; if (bus.inflight_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_inflight: got %0d want 0", bus.inflight_cnt); end
    n_chk++; if (bus.underflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_underflow: got %b want 0", bus.underflow_err); end
    @(posedge clk);
    #1;
    n_chk++; if (bus.pending_mask !== 16'h0 || bus.inflight_cnt !== 4'd0) begin
      n_fail++; $display("FAIL reset_edge_held: got mask=%h cnt=%0d want 0000/0", bus.pending_mask, bus.inflight_cnt);
    end
    apply(idle());
    rst = 1'b1;
  endtask

  task automatic test_raw();
    stim_t t[$];
    exp_t  e;
    t.push_back(mk(1, 1, 2,  0, 0, 0, 0, 0, 0, 0, 0,  0));
    t.push_back(mk(1, 1, 10, 2, 1, 0, 0, 0, 0, 0, 0,  1));
    t.push_back(mk(1, 1, 10, 2, 1, 0, 0, 0, 0, 0, 0,  1));
    t.push_back(mk(1, 1, 10, 2, 1, 0, 0, 0, 0, 1, 2,  1));
    t.push_back(mk(1, 1, 10, 2, 1, 0, 0, 0, 0, 0, 0,  0));
    t.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 10, 0));
    foreach (t[i]) begin
      apply(t[i]); #1;
      n_chk++; if (bus.hazard !== t[i].exp_h) begin n_fail++; $display("FAIL raw_hazard[%0d]: got %b want %b", i, bus.hazard, t[i].exp_h); end
      tick(t[i]);
      e = exp_q.pop_front();
      n_chk++; if ({bus.pending_mask, bus.inflight_cnt, bus.underflow_err} !== e) begin
        n_fail++; $display("FAIL raw_state[%0d]: got %h/%0d/%b want %h/%0d/%b", i, bus.pending_mask, bus.inflight_cnt, bus.underflow_err, e[20:5], e[4:1], e[0]);
      end
    end
  endtask

  task automatic test_same_cycle();
    stim_t t[$];
    exp_t  e;
    t.push_back(mk(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(1, 1, 4, 0, 0, 0, 0, 0, 0, 1, 4, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0));
    foreach (t[i]) begin
      apply(t[i]); #1;
      n_chk++; if (bus.hazard !== t[i].exp_h) begin n_fail++; $display("FAIL same_hazard[%0d]: got %b want %b", i, bus.hazard, t[i].exp_h); end
      tick(t[i]);
      e = exp_q.pop_front();
      n_chk++; if ({bus.pending_mask, bus.inflight_cnt, bus.underflow_err} !== e) begin
        n_fail++; $display("FAIL same_state[%0d]: got %h/%0d/%b want %h/%0d/%b", i, bus.pending_mask, bus.inflight_cnt, bus.underflow_err, e[20:5], e[4:1], e[0]);
      end
    end
  endtask

  task automatic test_overflow();
    stim_t t[$];
    exp_t  e;
    repeat (3) t.push_back(mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    t.push_back(mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 1, 7, 1));
    t.push_back(mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0));
    foreach (t[i]) begin
      apply(t[i]); #1;
      n_chk++; if (bus.hazard !== t[i].exp_h) begin n_fail++; $display("FAIL ovf_hazard[%0d]: got %b want %b", i, bus.hazard, t[i].exp_h); end
      tick(t[i]);
      e = exp_q.pop_front();
      n_chk++; if ({bus.pending_mask, bus.inflight_cnt, bus.underflow_err} !== e) begin
        n_fail++; $display("FAIL ovf_state[%0d]: got %h/%0d/%b want %h/%0d/%b", i, bus.pending_mask, bus.inflight_cnt, bus.underflow_err, e[20:5], e[4:1], e[0]);
      end
      if (i == 5) begin
        n_chk++; if (bus.inflight_cnt !== 4'd3) begin n_fail++; $display("FAIL ovf_reissue_count: got %0d want 3", bus.inflight_cnt); end
      end
    end
  endtask

  task automatic test_flush_freeze();
    stim_t t[$];
    exp_t  e;
    t.push_back(mk(1, 1, 6,  0, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(1, 1, 11, 0, 0, 6, 1, 0, 1, 0, 0, 0));
    t.push_back(mk(1, 1, 11, 0, 0, 6, 1, 0, 0, 0, 0, 1));
    t.push_back(mk(1, 1, 12, 0, 0, 0, 0, 1, 0, 1, 6, 0));
    t.push_back(mk(1, 1, 12, 6, 1, 0, 0, 1, 0, 1, 6, 1));
    t.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 6, 0));
    t.push_back(mk(1, 1, 0,  0, 0, 6, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0));
    foreach (t[i]) begin
      apply(t[i]); #1;
      n_chk++; if (bus.hazard !== t[i].exp_h) begin n_fail++; $display("FAIL ff_hazard[%0d]: got %b want %b", i, bus.hazard, t[i].exp_h); end
      tick(t[i]);
      e = exp_q.pop_front();
      n_chk++; if ({bus.pending_mask, bus.inflight_cnt, bus.underflow_err} !== e) begin
        n_fail++; $display("FAIL ff_state[%0d]: got %h/%0d/%b want %h/%0d/%b", i, bus.pending_mask, bus.inflight_cnt, bus.underflow_err, e[20:5], e[4:1], e[0]);
      end
    end
  endtask

  task automatic test_underflow();
    stim_t t[$];
    exp_t  e;
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0));
    repeat (10) t.push_back(idle());
    foreach (t[i]) begin
      apply(t[i]); #1;
      n_chk++; if (bus.hazard !== t[i].exp_h) begin n_fail++; $display("FAIL uf_hazard[%0d]: got %b want %b", i, bus.hazard, t[i].exp_h); end
      tick(t[i]);
      e = exp_q.pop_front();
      n_chk++; if ({bus.pending_mask, bus.inflight_cnt, bus.underflow_err} !== e) begin
        n_fail++; $display("FAIL uf_state[%0d]: got %h/%0d/%b want %h/%0d/%b", i, bus.pending_mask, bus.inflight_cnt, bus.underflow_err, e[20:5], e[4:1], e[0]);
      end
    end
    n_chk++; if (bus.underflow_err !== 1'b1 || bus.pending_mask[9] !== 1'b0) begin
      n_fail++; $display("FAIL uf_sticky: got err=%b pend9=%b want 1/0", bus.underflow_err, bus.pending_mask[9]);
    end
  endtask

  task automatic test_reset_midrun();
    stim_t t[$];
    exp_t  e;
    t.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (t[i]) begin
      apply(t[i]); #1;
      tick(t[i]);
      e = exp_q.pop_front();
      n_chk++; if ({bus.pending_mask, bus.inflight_cnt, bus.underflow_err} !== e) begin
        n_fail++; $display("FAIL mid_build[%0d]: got %h/%0d/%b want %h/%0d/%b", i, bus.pending_mask, bus.inflight_cnt, bus.underflow_err, e[20:5], e[4:1], e[0]);
      end
    end
    apply(mk(1, 1, 8, 3, 1, 5, 1, 0, 0, 0, 0, 1));
    #1;
    n_chk++; if (bus.hazard !== 1'b1) begin n_fail++; $display("FAIL mid_pre_hazard: got %b want 1", bus.hazard); end
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    n_chk++; if (bus.hazard !== 1'b0) begin n_fail++; $display("FAIL mid_hazard: got %b want 0", bus.hazard); end
    n_chk++; if (bus.pending_mask !== 16'h0) begin n_fail++; $display("FAIL mid_mask: got %h want 0000", bus.pending_mask); end
    n_chk++; if (bus.inflight_cnt !== 4'd0 || bus.underflow_err !== 1'b0) begin
      n_fail++; $display("FAIL mid_cnt: got cnt=%0d err=%b want 0/0", bus.inflight_cnt, bus.underflow_err);
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    t.delete();
    t.push_back(mk(1, 1, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0));
    foreach (t[i]) begin
      apply(t[i]); #1;
      n_chk++; if (bus.hazard !== t[i].exp_h) begin n_fail++; $display("FAIL post_hazard[%0d]: got %b want %b", i, bus.hazard, t[i].exp_h); end
      tick(t[i]);
      e = exp_q.pop_front();
      n_chk++; if ({bus.pending_mask, bus.inflight_cnt, bus.underflow_err} !== e) begin
        n_fail++; $display("FAIL post_state[%0d]: got %h/%0d/%b want %h/%0d/%b", i, bus.pending_mask, bus.inflight_cnt, bus.underflow_err, e[20:5], e[4:1], e[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    exp_t  e;
    for (int i = 0; i < 300; i++) begin
      s = mk($urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom_range(0, 3)),
             4'($urandom_range(0, 3)), $urandom_range(0, 1), 4'($urandom_range(0, 3)),
             $urandom_range(0, 1), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
             $urandom_range(0, 1), 4'($urandom_range(0, 3)), 1'b0);
      s.exp_h = model_haz(s);
      apply(s); #1;
      n_chk++; if (bus.hazard !== s.exp_h) begin n_fail++; $display("FAIL b2b_hazard[%0d]: got %b want %b", i, bus.hazard, s.exp_h); end
      tick(s);
      e = exp_q.pop_front();
      n_chk++; if ({bus.pending_mask, bus.inflight_cnt, bus.underflow_err} !== e) begin
        n_fail++; $display("FAIL b2b_state[%0d]: got %h/%0d/%b want %h/%0d/%b", i, bus.pending_mask, bus.inflight_cnt, bus.underflow_err, e[20:5], e[4:1], e[0]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_raw();
    test_same_cycle();
    test_overflow();
    test_flush_freeze();
    test_underflow();
    test_reset_midrun();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
